// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding,
// the default operand width and the bit-counter width helper.
`timescale 1ns/1ps

package serial_sub_pkg;

  // Default operand/result width in bits (legal range 2..16).
  localparam int DEFAULT_WIDTH = 8;

  // Controller states: waiting for operands, shifting bits, holding result.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Bit counter width: clog2(WIDTH), never narrower than one bit.
  function automatic int cnt_width(input int width);
    if (width <= 2) begin
      return 1;
    end
    return $clog2(width);
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// Single-bit full subtractor cell: d = x - y - bin, with borrow out.
// Mirror image of the ripple adder's full-adder cell.
`timescale 1ns/1ps

module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  logic x_xor_y;

  // Difference bit and borrow-out, purely combinational.
  always_comb begin
    x_xor_y = x ^ y;
    d       = x_xor_y ^ bin;
    bout    = (~x & y) | (~x_xor_y & bin);
  end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes (a - b) mod 2^WIDTH one bit per clock,
// LSB first, with a registered borrow between bit positions.
// Operands enter through a valid/ready handshake; the result is held on a
// valid/ready output handshake until the consumer takes it.
// Optional feature macro: SERIAL_SUB_OVF_EN adds the registered ovf output
// (two's-complement overflow of the subtraction).
`timescale 1ns/1ps

module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             zero
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int             CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0]  LAST_CNT = CW'(WIDTH - 1);

  // Controller and datapath state.
  state_e           state_q,     state_d;
  logic [WIDTH-1:0] a_sr_q,      a_sr_d;
  logic [WIDTH-1:0] b_sr_q,      b_sr_d;
  logic [WIDTH-1:0] dsr_q,       dsr_d;
  logic             br_q,        br_d;
  logic [CW-1:0]    cnt_q,       cnt_d;

  // Registered outputs; the result registers are only non-zero in DONE.
  logic             in_ready_q,  in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] diff_q,      diff_d;
  logic             borrow_q,    borrow_d;
  logic             zero_q,      zero_d;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf_q,       ovf_d;
`endif

  // Single full-subtractor cell working on the current LSB of each operand.
  logic             fs_d;
  logic             fs_bout;
  logic [WIDTH-1:0] dsr_shifted;

  full_subtractor u_fs (
    .x    (a_sr_q[0]),
    .y    (b_sr_q[0]),
    .bin  (br_q),
    .d    (fs_d),
    .bout (fs_bout)
  );

  // The new difference bit enters at the MSB, so after WIDTH shifts the
  // LSB-first stream has landed in its natural bit positions.
  assign dsr_shifted = {fs_d, dsr_q[WIDTH-1:1]};

  // Next-state logic for the handshake FSM and the serial datapath.
  always_comb begin
    state_d     = state_q;
    a_sr_d      = a_sr_q;
    b_sr_d      = b_sr_q;
    dsr_d       = dsr_q;
    br_d        = br_q;
    cnt_d       = cnt_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    diff_d      = diff_q;
    borrow_d    = borrow_q;
    zero_d      = zero_q;
`ifdef SERIAL_SUB_OVF_EN
    ovf_d       = ovf_q;
`endif

    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          a_sr_d     = a;
          b_sr_d     = b;
          dsr_d      = '0;
          br_d       = 1'b0;
          cnt_d      = '0;
          in_ready_d = 1'b0;
          state_d    = RUN;
        end
      end

      RUN: begin
        a_sr_d = a_sr_q >> 1;
        b_sr_d = b_sr_q >> 1;
        dsr_d  = dsr_shifted;
        br_d   = fs_bout;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == LAST_CNT) begin
          // Final (MSB) stage: the borrow out of this stage is the
          // unsigned borrow of the whole subtraction.
          cnt_d       = '0;
          out_valid_d = 1'b1;
          diff_d      = dsr_shifted;
          borrow_d    = fs_bout;
          zero_d      = (dsr_shifted == '0);
`ifdef SERIAL_SUB_OVF_EN
          // Signed overflow: borrow into MSB differs from borrow out of it.
          ovf_d       = br_q ^ fs_bout;
`endif
          state_d     = DONE;
        end
      end

      DONE: begin
        // No bypass into a new operation: the block always passes through
        // IDLE for one cycle before accepting operands again.
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          diff_d      = '0;
          borrow_d    = 1'b0;
          zero_d      = 1'b0;
`ifdef SERIAL_SUB_OVF_EN
          ovf_d       = 1'b0;
`endif
          state_d     = IDLE;
        end
      end

      default: begin
        // Unreachable encoding: recover to an idle, empty block.
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        diff_d      = '0;
        borrow_d    = 1'b0;
        zero_d      = 1'b0;
`ifdef SERIAL_SUB_OVF_EN
        ovf_d       = 1'b0;
`endif
        cnt_d       = '0;
        br_d        = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  // State registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_sr_q      <= '0;
      b_sr_q      <= '0;
      dsr_q       <= '0;
      br_q        <= 1'b0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      diff_q      <= '0;
      borrow_q    <= 1'b0;
      zero_q      <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      a_sr_q      <= a_sr_d;
      b_sr_q      <= b_sr_d;
      dsr_q       <= dsr_d;
      br_q        <= br_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      diff_q      <= diff_d;
      borrow_q    <= borrow_d;
      zero_q      <= zero_d;
`ifdef SERIAL_SUB_OVF_EN
      ovf_q       <= ovf_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign diff      = diff_q;
  assign borrow    = borrow_q;
  assign zero      = zero_q;
`ifdef SERIAL_SUB_OVF_EN
  assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor (WIDTH=8).
// Checks ovf as well when built with SERIAL_SUB_OVF_EN.
`timescale 1ns/1ps

module tb_serial_subtractor;

  localparam int W      = 8;
  localparam int MAXLAT = 40;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a_i;
  logic [W-1:0] b_i;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] diff;
  logic         borrow;
  logic         zero;
  logic         ovf_w;

  int checks   = 0;
  int failures = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a_i),
    .b         (b_i),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .borrow    (borrow),
    .zero      (zero)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf       (ovf_w)
`endif
  );

`ifndef SERIAL_SUB_OVF_EN
  assign ovf_w = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one operand pair (caller ensures in_ready=1), then wait a bounded
  // number of cycles for out_valid. lat counts edges after the accept edge.
  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                        output int lat, output logic [W-1:0] d,
                        output logic bo, output logic z, output logic ov);
    a_i      = av;
    b_i      = bv;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < MAXLAT) begin
      @(posedge clk); #1;
      lat++;
    end
    d  = diff;
    bo = borrow;
    z  = zero;
    ov = ovf_w;
  endtask

  // Hand the result to the consumer with a one-cycle out_ready pulse.
  task automatic drain();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a_i = '0; b_i = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (diff !== 8'h00) begin failures++; $display("FAIL reset_diff got=%h exp=00", diff); end
    checks++; if (borrow !== 1'b0 || zero !== 1'b0) begin failures++; $display("FAIL reset_flags got borrow=%b zero=%b exp=0/0", borrow, zero); end
`ifdef SERIAL_SUB_OVF_EN
    checks++; if (ovf_w !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b exp=0", ovf_w); end
`endif
    rst_n = 1'b1;
    @(posedge clk); #1;
    $display("reset: in_ready=%b out_valid=%b diff=%h", in_ready, out_valid, diff);
  endtask

  task automatic test_basic();
    int lat; logic [W-1:0] d; logic bo, z, ov;
    run_op(8'h05, 8'h03, lat, d, bo, z, ov);
    $display("op 05-03: lat=%0d diff=%h borrow=%b zero=%b ovf=%b", lat, d, bo, z, ov);
    checks++; if (lat != W) begin failures++; $display("FAIL basic_latency got=%0d exp=%0d", lat, W); end
    checks++; if (d !== 8'h02) begin failures++; $display("FAIL basic_diff got=%h exp=02", d); end
    checks++; if (bo !== 1'b0 || z !== 1'b0) begin failures++; $display("FAIL basic_flags got borrow=%b zero=%b exp=0/0", bo, z); end
`ifdef SERIAL_SUB_OVF_EN
    checks++; if (ov !== 1'b0) begin failures++; $display("FAIL basic_ovf got=%b exp=0", ov); end
`endif
    drain();
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL basic_drain got out_valid=%b in_ready=%b exp=0/1", out_valid, in_ready); end
    checks++; if (diff !== 8'h00) begin failures++; $display("FAIL basic_diff_cleared got=%h exp=00", diff); end
  endtask

  task automatic test_borrow();
    int lat; logic [W-1:0] d; logic bo, z, ov;
    run_op(8'h03, 8'h05, lat, d, bo, z, ov);
    $display("op 03-05: lat=%0d diff=%h borrow=%b zero=%b ovf=%b", lat, d, bo, z, ov);
    checks++; if (d !== 8'hFE) begin failures++; $display("FAIL borrow_diff got=%h exp=fe", d); end
    checks++; if (bo !== 1'b1) begin failures++; $display("FAIL borrow_flag got=%b exp=1", bo); end
    checks++; if (z !== 1'b0) begin failures++; $display("FAIL borrow_zero got=%b exp=0", z); end
`ifdef SERIAL_SUB_OVF_EN
    checks++; if (ov !== 1'b0) begin failures++; $display("FAIL borrow_ovf got=%b exp=0", ov); end
`endif
    drain();
  endtask

  task automatic test_zero();
    int lat; logic [W-1:0] d; logic bo, z, ov;
    run_op(8'h80, 8'h80, lat, d, bo, z, ov);
    $display("op 80-80: lat=%0d diff=%h borrow=%b zero=%b ovf=%b", lat, d, bo, z, ov);
    checks++; if (d !== 8'h00) begin failures++; $display("FAIL zero_diff got=%h exp=00", d); end
    checks++; if (bo !== 1'b0) begin failures++; $display("FAIL zero_borrow got=%b exp=0", bo); end
    checks++; if (z !== 1'b1) begin failures++; $display("FAIL zero_flag got=%b exp=1", z); end
    drain();
`ifdef SERIAL_SUB_OVF_EN
    run_op(8'h80, 8'h01, lat, d, bo, z, ov);
    $display("op 80-01: lat=%0d diff=%h borrow=%b zero=%b ovf=%b", lat, d, bo, z, ov);
    checks++; if (d !== 8'h7F) begin failures++; $display("FAIL ovf_diff got=%h exp=7f", d); end
    checks++; if (ov !== 1'b1 || bo !== 1'b0) begin failures++; $display("FAIL ovf_flag got ovf=%b borrow=%b exp=1/0", ov, bo); end
    drain();
`endif
  endtask

  task automatic test_backpressure();
    int lat; logic [W-1:0] d; logic bo, z, ov;
    run_op(8'hC8, 8'h37, lat, d, bo, z, ov);
    $display("op c8-37: lat=%0d diff=%h borrow=%b zero=%b", lat, d, bo, z);
    checks++; if (d !== 8'h91 || bo !== 1'b0) begin failures++; $display("FAIL bp_result got diff=%h borrow=%b exp=91/0", d, bo); end
    // New operands offered while the result is held must be ignored.
    a_i = 8'h00; b_i = 8'h00; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || diff !== 8'h91 || borrow !== 1'b0 || zero !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold cycle=%0d got v=%b rdy=%b diff=%h b=%b z=%b exp 1/0/91/0/0", i, out_valid, in_ready, diff, borrow, zero);
      end
    end
    in_valid = 1'b0;
    drain();
    $display("backpressure release: out_valid=%b in_ready=%b diff=%h", out_valid, in_ready, diff);
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL bp_release got out_valid=%b in_ready=%b exp=0/1", out_valid, in_ready); end
  endtask

  task automatic test_reset_mid_run();
    int lat; logic [W-1:0] d; logic bo, z, ov;
    a_i = 8'hFF; b_i = 8'h01; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    $display("mid-run reset: in_ready=%b out_valid=%b diff=%h", in_ready, out_valid, diff);
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL abort_ctrl got in_ready=%b out_valid=%b exp=1/0", in_ready, out_valid); end
    checks++; if (diff !== 8'h00 || borrow !== 1'b0 || zero !== 1'b0) begin failures++; $display("FAIL abort_outputs got diff=%h b=%b z=%b exp=00/0/0", diff, borrow, zero); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(8'h10, 8'h01, lat, d, bo, z, ov);
    $display("op 10-01: lat=%0d diff=%h borrow=%b zero=%b", lat, d, bo, z);
    checks++; if (lat != W) begin failures++; $display("FAIL after_abort_latency got=%0d exp=%0d", lat, W); end
    checks++; if (d !== 8'h0F || bo !== 1'b0 || z !== 1'b0) begin failures++; $display("FAIL after_abort_result got diff=%h b=%b z=%b exp=0f/0/0", d, bo, z); end
    drain();
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] av [3];
    logic [W-1:0] bv [3];
    logic [W-1:0] ed [3];
    logic         eb [3];
    logic         ez [3];
    logic [W-1:0] gd [4];
    logic         gb [4];
    logic         gz [4];
    int           gt [4];
    int           idx = 0;
    int           nres = 0;
    logic         acc, fire;
    logic [W-1:0] sd;
    logic         sb, sz;
    av[0] = 8'h55; bv[0] = 8'h22; ed[0] = 8'h33; eb[0] = 1'b0; ez[0] = 1'b0;
    av[1] = 8'h01; bv[1] = 8'h02; ed[1] = 8'hFF; eb[1] = 1'b1; ez[1] = 1'b0;
    av[2] = 8'hAA; bv[2] = 8'hAA; ed[2] = 8'h00; eb[2] = 1'b0; ez[2] = 1'b1;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 60; cyc++) begin
      in_valid = (idx < 3);
      if (idx < 3) begin a_i = av[idx]; b_i = bv[idx]; end
      acc  = in_valid && in_ready;
      fire = out_valid && out_ready;
      sd = diff; sb = borrow; sz = zero;
      @(posedge clk); #1;
      if (acc) idx++;
      if (fire) begin
        if (nres < 4) begin gd[nres] = sd; gb[nres] = sb; gz[nres] = sz; gt[nres] = cyc; end
        $display("b2b result %0d at cycle %0d: diff=%h borrow=%b zero=%b", nres, cyc, sd, sb, sz);
        nres++;
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    checks++; if (nres != 3) begin failures++; $display("FAIL b2b_count got=%0d exp=3", nres); end
    for (int k = 0; k < 3; k++) begin
      if (k < nres) begin
        checks++;
        if (gd[k] !== ed[k] || gb[k] !== eb[k] || gz[k] !== ez[k]) begin
          failures++;
          $display("FAIL b2b_result%0d got diff=%h b=%b z=%b exp %h/%b/%b", k, gd[k], gb[k], gz[k], ed[k], eb[k], ez[k]);
        end
        if (k > 0) begin
          checks++;
          if (gt[k] - gt[k-1] != W + 2) begin failures++; $display("FAIL b2b_spacing%0d got=%0d exp=%0d", k, gt[k] - gt[k-1], W + 2); end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_borrow();
    test_zero();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
